// File: rtl/core_pkg.sv
// Shared core definitions: result-select and ALU encodings, the packed
// decode/execute control word, and a small helper used by hazard logic.
package core_pkg;

  // Result-select encodings for the writeback mux.
  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_LOAD = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_IMM  = 2'b11
  } result_src_e;

  // ALU operation encodings.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  // Control word carried from decode into execute.
  typedef struct packed {
    logic [2:0] regwrite;
    logic [1:0] memwrite;
    logic [1:0] resultsrc;
    logic [2:0] aluctrl;
    logic       alusrc;
    logic       jump;
    logic       branch;
  } ctrl_t;

  // A bubble carries no side effects; all fields zero keeps waveforms clean.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // True when the result select picks load data.
  function automatic logic is_load(input logic [1:0] resultsrc);
    return resultsrc == RESULT_LOAD;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator. Flags when the instruction in E is a valid
// register-writing load whose destination (non-zero) is a source of the
// valid instruction in D.
//   validE, RegWriteE, ResultsrcE, RdE : execute-stage state
//   validD, Rs1D, Rs2D                 : decode-stage instruction
//   load_use                           : combinational hazard flag
module load_use_detect
  import core_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      validE,
  input  logic [2:0]                RegWriteE,
  input  logic [1:0]                ResultsrcE,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic                      validD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  output logic                      load_use
);

  logic rd_match;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign rd_match = (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  assign load_use = validE && validD && (RegWriteE != 3'b000) &&
                    is_load(ResultsrcE) && rd_match;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register. Latches the decode control word and
// operands into E, inserts one bubble per load-use hazard (stalling F/D for
// that cycle), honours an external hold and branch/jump flushes, and keeps a
// saturating count of load-use bubbles.
//   clk, rst          : clock, synchronous active-high reset
//   stall_i, flush_i  : external hold of E, squash of incoming D instruction
//   *D inputs         : decode-stage control word, operands and indices
//   *E outputs        : registered execute-stage copies of the D inputs
//   validE            : E holds a real instruction
//   StallF, StallD    : combinational load-use stall requests
//   bubble_cnt        : saturating count of load-use bubbles
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      validD,
  input  logic [2:0]                RegWriteD,
  input  logic [1:0]                MemWriteD,
  input  logic [1:0]                ResultsrcD,
  input  logic [2:0]                ALUctrlD,
  input  logic                      ALUsrcD,
  input  logic                      JumpD,
  input  logic                      BranchD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  output logic                      validE,
  output logic [2:0]                RegWriteE,
  output logic [1:0]                MemWriteE,
  output logic [1:0]                ResultsrcE,
  output logic [2:0]                ALUctrlE,
  output logic                      ALUsrcE,
  output logic                      JumpE,
  output logic                      BranchE,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      StallF,
  output logic                      StallD,
  output logic [CNT_WIDTH-1:0]      bubble_cnt
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_e;
  logic  load_use;

  // Gather decode control into one word.
  assign ctrl_d = '{regwrite:  RegWriteD,
                    memwrite:  MemWriteD,
                    resultsrc: ResultsrcD,
                    aluctrl:   ALUctrlD,
                    alusrc:    ALUsrcD,
                    jump:      JumpD,
                    branch:    BranchD};

  // Execute control outputs come straight from the control-word flops.
  assign RegWriteE  = ctrl_e.regwrite;
  assign MemWriteE  = ctrl_e.memwrite;
  assign ResultsrcE = ctrl_e.resultsrc;
  assign ALUctrlE   = ctrl_e.aluctrl;
  assign ALUsrcE    = ctrl_e.alusrc;
  assign JumpE      = ctrl_e.jump;
  assign BranchE    = ctrl_e.branch;

  // Hazard check of D sources against the instruction currently in E.
  load_use_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use_detect (
    .validE     (validE),
    .RegWriteE  (ctrl_e.regwrite),
    .ResultsrcE (ctrl_e.resultsrc),
    .RdE        (RdE),
    .validD     (validD),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .load_use   (load_use)
  );

  // A flush already squashes D and an external hold is owned elsewhere, so
  // only a real load-use bubble freezes F/D.
  assign StallF = load_use && !flush_i && !stall_i;
  assign StallD = load_use && !flush_i && !stall_i;

  // E register bank: reset > hold > flush/load-use bubble > capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      validE     <= 1'b0;
      ctrl_e     <= CTRL_BUBBLE;
      RD1E       <= '0;
      RD2E       <= '0;
      PCE        <= '0;
      PCPlus4E   <= '0;
      ImmExtE    <= '0;
      Rs1E       <= '0;
      Rs2E       <= '0;
      RdE        <= '0;
      bubble_cnt <= '0;
    end else if (!stall_i) begin
      if (flush_i || load_use) begin
        validE   <= 1'b0;
        ctrl_e   <= CTRL_BUBBLE;
        RD1E     <= '0;
        RD2E     <= '0;
        PCE      <= '0;
        PCPlus4E <= '0;
        ImmExtE  <= '0;
        Rs1E     <= '0;
        Rs2E     <= '0;
        RdE      <= '0;
      end else begin
        validE   <= validD;
        ctrl_e   <= ctrl_d;
        RD1E     <= RD1D;
        RD2E     <= RD2D;
        PCE      <= PCD;
        PCPlus4E <= PCPlus4D;
        ImmExtE  <= ImmExtD;
        Rs1E     <= Rs1D;
        Rs2E     <= Rs2D;
        RdE      <= RdD;
      end
      // Only load-use bubbles are counted; a flush takes precedence.
      if (load_use && !flush_i && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors carry their hand-chosen
// outcome; the driver queues expectations and a monitor checks them.
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic          vd;
    logic [2:0]    rw;
    logic [1:0]    mw;
    logic [1:0]    rs;
    logic [2:0]    alu;
    logic          alusrc;
    logic          j;
    logic          b;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] pc;
    logic [DW-1:0] pc4;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
  } din_t;

  typedef enum logic [1:0] {K_CAP, K_BUB, K_HOLD} kind_e;

  typedef struct packed {
    din_t          d;
    logic          rst;
    logic          stl;
    logic          fl;
    kind_e         k;
    logic [CW-1:0] cnt;
    logic          st;
    logic          chk;
  } vec_t;

  typedef struct packed {
    logic          v;
    logic [13:0]   ctrl;
    logic [159:0]  data;
    logic [14:0]   idx;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    exp_t       e;
    logic [1:0] st;
    logic       chk;
    int         id;
  } rec_t;

  logic clk = 1'b0;
  logic rst, stall_i, flush_i, validD;
  logic [2:0] RegWriteD, ALUctrlD;
  logic [1:0] MemWriteD, ResultsrcD;
  logic ALUsrcD, JumpD, BranchD;
  logic [DW-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [AW-1:0] Rs1D, Rs2D, RdD;
  logic validE, ALUsrcE, JumpE, BranchE, StallF, StallD;
  logic [2:0] RegWriteE, ALUctrlE;
  logic [1:0] MemWriteE, ResultsrcE;
  logic [DW-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [AW-1:0] Rs1E, Rs2E, RdE;
  logic [CW-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vq[$];
  rec_t sq[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .validD(validD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultsrcD(ResultsrcD),
    .ALUctrlD(ALUctrlD), .ALUsrcD(ALUsrcD), .JumpD(JumpD), .BranchD(BranchD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .validE(validE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultsrcE(ResultsrcE), .ALUctrlE(ALUctrlE), .ALUsrcE(ALUsrcE),
    .JumpE(JumpE), .BranchE(BranchE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .StallF(StallF), .StallD(StallD), .bubble_cnt(bubble_cnt)
  );

  function automatic din_t ins(input logic [2:0] rw, input logic [1:0] rs,
                               input logic [2:0] alu, input logic [AW-1:0] rs1,
                               input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                               input logic [DW-1:0] base);
    din_t d;
    d        = '0;
    d.vd     = 1'b1;
    d.rw     = rw;
    d.rs     = rs;
    d.alu    = alu;
    d.alusrc = base[0];
    d.j      = base[1];
    d.b      = base[2];
    d.rd1    = base;
    d.rd2    = ~base;
    d.pc     = base << 2;
    d.pc4    = (base << 2) + 32'd4;
    d.imm    = base + 32'h100;
    d.rs1    = rs1;
    d.rs2    = rs2;
    d.rd     = rd;
    return d;
  endfunction

  function automatic din_t ld(input logic [AW-1:0] rd, input logic [DW-1:0] base);
    return ins(3'b001, 2'b01, ALU_ADD, 5'd1, 5'd2, rd, base);
  endfunction

  task automatic add(input din_t d, input logic r, input logic s, input logic f,
                     input kind_e k, input int cnt, input logic st, input logic chk);
    vec_t v;
    v.d = d; v.rst = r; v.stl = s; v.fl = f; v.k = k;
    v.cnt = CW'(cnt); v.st = st; v.chk = chk;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int id, input logic [159:0] got,
                       input logic [159:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s vec%0d got %h want %h", name, id, got, want);
    end
  endtask

  // Build the directed vector table.
  initial begin
    din_t n, u, s;
    int c;
    n = '0;
    add(n, 1, 0, 0, K_BUB, 0, 0, 0);                               // 0 reset
    add(ld(5'd5, 32'h1000), 0, 0, 0, K_CAP, 0, 0, 1);              // 1 load rd5
    add(n, 1, 0, 0, K_BUB, 0, 0, 1);                               // 2 mid-stream reset
    add(ins(3'b001, 2'b00, ALU_SUB, 5'd5, 5'd4, 5'd7, 32'h10),
        0, 0, 0, K_CAP, 0, 0, 1);                                  // 3 plain capture
    add(ins(3'b001, 2'b01, ALU_ADD, 5'd7, 5'd0, 5'd5, 32'h2000),
        0, 0, 0, K_CAP, 0, 0, 1);                                  // 4 load rd5
    u = ins(3'b001, 2'b00, ALU_AND, 5'd9, 5'd5, 5'd6, 32'h30);
    add(u, 0, 0, 0, K_BUB, 1, 1, 1);                               // 5 load-use
    add(u, 0, 0, 0, K_CAP, 1, 0, 1);                               // 6 held D captured
    add(ld(5'd0, 32'h40), 0, 0, 0, K_CAP, 1, 0, 1);                // 7 load rd0
    add(ins(3'b001, 2'b00, ALU_OR, 5'd0, 5'd0, 5'd8, 32'h50),
        0, 0, 0, K_CAP, 1, 0, 1);                                  // 8 no stall on x0
    add(ld(5'd5, 32'h60), 0, 0, 0, K_CAP, 1, 0, 1);                // 9
    n = ins(3'b001, 2'b00, ALU_XOR, 5'd5, 5'd5, 5'd9, 32'h66);
    n.vd = 1'b0;
    add(n, 0, 0, 0, K_CAP, 1, 0, 1);                               // 10 validD=0
    s = ins(3'b000, 2'b00, ALU_ADD, 5'd3, 5'd4, 5'd0, 32'h70);
    s.mw = 2'b01;
    add(s, 0, 0, 1, K_BUB, 1, 0, 1);                               // 11 flush store
    add(ld(5'd5, 32'h80), 0, 0, 0, K_CAP, 1, 0, 1);                // 12
    add(ins(3'b001, 2'b00, ALU_ADD, 5'd5, 5'd1, 5'd2, 32'h84),
        0, 0, 1, K_BUB, 1, 0, 1);                                  // 13 flush beats load-use
    add(ld(5'd5, 32'h90), 0, 0, 0, K_CAP, 1, 0, 1);                // 14
    for (int i = 0; i < 3; i++)                                    // 15-17 hold
      add(ins(3'b001, 2'b00, ALU_OR, 5'd5, 5'(i), 5'(10 + i), 32'hA0 + 32'(i)),
          0, 1, 1, K_HOLD, 1, 0, 1);
    add(ins(3'b001, 2'b00, ALU_OR, 5'd5, 5'd0, 5'd12, 32'hA8),
        0, 0, 1, K_BUB, 1, 0, 1);                                  // 18 release -> bubble
    add(ld(5'd5, 32'hB0), 0, 0, 0, K_CAP, 1, 0, 1);                // 19
    u = ins(3'b001, 2'b00, ALU_SUB, 5'd1, 5'd5, 5'd6, 32'hB4);
    add(u, 0, 1, 0, K_HOLD, 1, 0, 1);                              // 20 hold masks stall
    add(u, 0, 0, 0, K_BUB, 2, 1, 1);                               // 21
    add(u, 0, 0, 0, K_CAP, 2, 0, 1);                               // 22
    c = 2;
    for (int i = 0; i < 16; i++) begin                             // saturation
      add(ld(5'd5, 32'h1000 + 32'(i * 16)), 0, 0, 0, K_CAP, c, 0, 1);
      u = ins(3'b001, 2'b00, ALU_XOR, 5'd5, 5'd3, 5'd6, 32'h2000 + 32'(i * 16));
      c = (c < 15) ? c + 1 : 15;
      add(u, 0, 0, 0, K_BUB, c, 1, 1);
      add(u, 0, 0, 0, K_CAP, c, 0, 1);
    end
    n = '0;
    add(n, 0, 0, 0, K_CAP, 15, 0, 1);
    add(n, 0, 0, 0, K_CAP, 15, 0, 1);
  end

  // Driver: apply a vector just after each rising edge and queue its outcome.
  initial begin
    vec_t v;
    rec_t r;
    exp_t prev;
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    {validD, RegWriteD, MemWriteD, ResultsrcD, ALUctrlD, ALUsrcD, JumpD, BranchD,
     RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD} = '0;
    prev = '0;
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(posedge clk);
      #2;
      rst = v.rst; stall_i = v.stl; flush_i = v.fl;
      {validD, RegWriteD, MemWriteD, ResultsrcD, ALUctrlD, ALUsrcD, JumpD, BranchD,
       RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD} = v.d;
      case (v.k)
        K_CAP: begin
          r.e.v    = v.d.vd;
          r.e.ctrl = {v.d.rw, v.d.mw, v.d.rs, v.d.alu, v.d.alusrc, v.d.j, v.d.b};
          r.e.data = {v.d.rd1, v.d.rd2, v.d.pc, v.d.pc4, v.d.imm};
          r.e.idx  = {v.d.rs1, v.d.rs2, v.d.rd};
        end
        K_HOLD:  r.e = prev;
        default: r.e = '0;
      endcase
      r.e.cnt = v.cnt;
      r.st    = {v.st, v.st};
      r.chk   = v.chk;
      r.id    = i;
      prev    = r.e;
      sq.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Monitor: mid-cycle, check this vector's stall and the previous vector's E.
  initial begin
    rec_t r;
    exp_t pend;
    int pid;
    bit have = 1'b0;
    pend = '0;
    pid  = 0;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        r = sq.pop_front();
        if (have) begin
          check("validE", pid, 160'(validE), 160'(pend.v));
          check("ctrlE", pid, 160'({RegWriteE, MemWriteE, ResultsrcE, ALUctrlE,
                                    ALUsrcE, JumpE, BranchE}), 160'(pend.ctrl));
          check("dataE", pid, {RD1E, RD2E, PCE, PCPlus4E, ImmExtE}, pend.data);
          check("idxE", pid, 160'({Rs1E, Rs2E, RdE}), 160'(pend.idx));
          check("bubble_cnt", pid, 160'(bubble_cnt), 160'(pend.cnt));
        end
        if (r.chk)
          check("stall", r.id, 160'({StallF, StallD}), 160'(r.st));
        pend = r.e;
        pid  = r.id;
        have = 1'b1;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    n_bad++;
    $display("FAIL timeout got running want finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
